// File: rtl/mem_ctrl_split.sv
// mem_ctrl_split
//   Byte-addressable data memory between the MEM stage and backing storage.
//   Word (16-bit) and byte accesses with a ready/valid handshake. Aligned word
//   and byte accesses complete one cycle after acceptance with no stall.
//   Misaligned word accesses are split into two byte accesses on consecutive
//   edges, so ready drops for one cycle. Out-of-range and illegal requests
//   complete with err and change no state.
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   synchronous, active-high; has priority over any request
//   addr    in   byte address of the request
//   wData   in   write data; byte writes use wData[7:0]
//   mRead   in   read request
//   mWrite  in   write request
//   mByte   in   1: byte access, 0: 16-bit word access
//   ready   out  request is accepted at this rising edge
//   rValid  out  one-cycle completion pulse
//   data    out  read data; holds until the next read completes
//   err     out  one-cycle fault pulse, coincident with rValid
//   memout  out  whole array, byte k at memout[8k +: 8]
module mem_ctrl_split #(
  parameter int ADDR_W      = 16,
  parameter int DEPTH_BYTES = 56,
  parameter bit BIG_ENDIAN  = 1'b1,
  parameter bit SIGN_EXT    = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [15:0]              wData,
  input  logic                     mRead,
  input  logic                     mWrite,
  input  logic                     mByte,
  output logic                     ready,
  output logic                     rValid,
  output logic [15:0]              data,
  output logic                     err,
  output logic [DEPTH_BYTES*8-1:0] memout
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);

  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic [1:0] {S_IDLE, S_SPLIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [7:0]  mem_q [DEPTH_BYTES];
  logic [7:0]  mem_d [DEPTH_BYTES];
  logic [15:0] data_q, data_d;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;

  // Second half of a split access, captured when the split is accepted.
  idx_t        split_idx_q, split_idx_d;
  logic        split_wr_q, split_wr_d;
  logic        split_err_q, split_err_d;
  logic [7:0]  split_wbyte_q, split_wbyte_d;
  logic [7:0]  split_rbyte_q, split_rbyte_d;   // first byte read in a split read

  // Request decode
  logic              req, bad, misaligned;
  logic [ADDR_W:0]   last_addr;
  idx_t              idx, idx_nxt;
  logic [7:0]        first_wbyte, second_wbyte;

  assign ready      = (state_q != S_SPLIT);
  assign req        = mRead | mWrite;
  assign misaligned = ~mByte & addr[0];
  // One extra bit so addr+1 cannot wrap back into range.
  assign last_addr  = {1'b0, addr} + {{ADDR_W{1'b0}}, ~mByte};
  assign bad        = (mRead & mWrite) | (last_addr >= (ADDR_W+1)'(DEPTH_BYTES));
  assign idx        = addr[IDX_W-1:0];
  assign idx_nxt    = idx + IDX_W'(1);

  // The byte at addr is the word MSB in big-endian mode, the LSB otherwise.
  assign first_wbyte  = (mByte || !BIG_ENDIAN) ? wData[7:0] : wData[15:8];
  assign second_wbyte = BIG_ENDIAN ? wData[7:0] : wData[15:8];

  function automatic logic [15:0] join_bytes(input logic [7:0] at_addr,
                                             input logic [7:0] at_next);
    return BIG_ENDIAN ? {at_addr, at_next} : {at_next, at_addr};
  endfunction

  function automatic logic [15:0] extend_byte(input logic [7:0] b);
    return {(SIGN_EXT ? {8{b[7]}} : 8'h00), b};
  endfunction

  // NOTE: every variable written here gets a default first, otherwise the
  // paths that do not assign it would infer a latch.
  always_comb begin
    state_d       = state_q;
    mem_d         = mem_q;
    data_d        = data_q;
    rvalid_d      = 1'b0;
    err_d         = 1'b0;
    split_idx_d   = split_idx_q;
    split_wr_d    = split_wr_q;
    split_err_d   = split_err_q;
    split_wbyte_d = split_wbyte_q;
    split_rbyte_d = split_rbyte_q;

    case (state_q)
      S_SPLIT: begin
        // Second half; the inputs are ignored this cycle.
        if (!split_err_q) begin
          if (split_wr_q) mem_d[split_idx_q] = split_wbyte_q;
          else            data_d = join_bytes(split_rbyte_q, mem_q[split_idx_q]);
        end
        rvalid_d = 1'b1;
        err_d    = split_err_q;
        state_d  = S_RESP;
      end

      default: begin  // S_IDLE and S_RESP both accept a new request
        state_d = S_IDLE;
        if (req) begin
          if (misaligned) begin
            state_d       = S_SPLIT;
            split_idx_d   = idx_nxt;
            split_wr_d    = mWrite;
            split_err_d   = bad;
            split_wbyte_d = second_wbyte;
            // A faulting split touches neither half.
            if (!bad) begin
              if (mWrite) mem_d[idx]    = first_wbyte;
              else        split_rbyte_d = mem_q[idx];
            end
          end else begin
            rvalid_d = 1'b1;
            err_d    = bad;
            if (!bad) begin
              if (mWrite) begin
                mem_d[idx] = first_wbyte;
                if (!mByte) mem_d[idx_nxt] = second_wbyte;
              end else if (mByte) begin
                data_d = extend_byte(mem_q[idx]);
              end else begin
                data_d = join_bytes(mem_q[idx], mem_q[idx_nxt]);
              end
            end
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      data_q        <= '0;
      rvalid_q      <= 1'b0;
      err_q         <= 1'b0;
      split_idx_q   <= '0;
      split_wr_q    <= 1'b0;
      split_err_q   <= 1'b0;
      split_wbyte_q <= '0;
      split_rbyte_q <= '0;
      // NOTE: the array is part of the architectural reset state, so it is
      // cleared here; this keeps it in flops rather than a RAM macro.
      for (int k = 0; k < DEPTH_BYTES; k++) mem_q[k] <= 8'h00;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      rvalid_q      <= rvalid_d;
      err_q         <= err_d;
      split_idx_q   <= split_idx_d;
      split_wr_q    <= split_wr_d;
      split_err_q   <= split_err_d;
      split_wbyte_q <= split_wbyte_d;
      split_rbyte_q <= split_rbyte_d;
      mem_q         <= mem_d;
    end
  end

  assign rValid = rvalid_q;
  assign err    = err_q;
  assign data   = data_q;

  for (genvar k = 0; k < DEPTH_BYTES; k++) begin : g_memout
    assign memout[8*k +: 8] = mem_q[k];
  end

endmodule

// File: tb/tb_mem_ctrl_split.sv
// tb_mem_ctrl_split
//   Directed bench for mem_ctrl_split. Three instances share one stimulus:
//   dut (big-endian, zero-extend), dut_sx (sign-extend) and dut_le
//   (little-endian). Inputs change on the falling edge; outputs are sampled
//   on the falling edge, i.e. mid-cycle after the accepting rising edge.
module tb_mem_ctrl_split;

  localparam int DEPTH = 56;

  logic             clk = 1'b0;
  logic             reset;
  logic [15:0]      addr;
  logic [15:0]      wData;
  logic             mRead, mWrite, mByte;

  logic             ready, rValid, err;
  logic [15:0]      data;
  logic [DEPTH*8-1:0] memout;

  logic             ready_sx, rvalid_sx, err_sx;
  logic [15:0]      data_sx;
  logic [DEPTH*8-1:0] memout_sx;

  logic             ready_le, rvalid_le, err_le;
  logic [15:0]      data_le;
  logic [DEPTH*8-1:0] memout_le;

  logic [DEPTH*8-1:0] snap;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  mem_ctrl_split #(.ADDR_W(16), .DEPTH_BYTES(DEPTH), .BIG_ENDIAN(1'b1), .SIGN_EXT(1'b0)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wData(wData), .mRead(mRead),
    .mWrite(mWrite), .mByte(mByte), .ready(ready), .rValid(rValid),
    .data(data), .err(err), .memout(memout));

  mem_ctrl_split #(.ADDR_W(16), .DEPTH_BYTES(DEPTH), .BIG_ENDIAN(1'b1), .SIGN_EXT(1'b1)) dut_sx (
    .clk(clk), .reset(reset), .addr(addr), .wData(wData), .mRead(mRead),
    .mWrite(mWrite), .mByte(mByte), .ready(ready_sx), .rValid(rvalid_sx),
    .data(data_sx), .err(err_sx), .memout(memout_sx));

  mem_ctrl_split #(.ADDR_W(16), .DEPTH_BYTES(DEPTH), .BIG_ENDIAN(1'b0), .SIGN_EXT(1'b0)) dut_le (
    .clk(clk), .reset(reset), .addr(addr), .wData(wData), .mRead(mRead),
    .mWrite(mWrite), .mByte(mByte), .ready(ready_le), .rValid(rvalid_le),
    .data(data_le), .err(err_le), .memout(memout_le));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mbyte(input logic [DEPTH*8-1:0] m, input int k);
    return m[8*k +: 8];
  endfunction

  // Single-cycle request: presented before edge N, returns mid-cycle N+1.
  task automatic req(input logic rd, input logic wr, input logic by,
                     input logic [15:0] a, input logic [15:0] wd);
    mRead = rd; mWrite = wr; mByte = by; addr = a; wData = wd;
    @(posedge clk);
    @(negedge clk);
    mRead = 1'b0; mWrite = 1'b0;
  endtask

  // Misaligned word request: checks the one-cycle stall, returns mid-cycle N+2.
  task automatic req_split(input logic rd, input logic wr, input logic [15:0] a,
                           input logic [15:0] wd, input logic [15:0] hold_data);
    mRead = rd; mWrite = wr; mByte = 1'b0; addr = a; wData = wd;
    @(posedge clk);
    @(negedge clk);
    check("split_ready_low", {31'd0, ready}, 32'd0);
    check("split_no_rvalid", {31'd0, rValid}, 32'd0);
    check("split_data_hold", {16'd0, data}, {16'd0, hold_data});
    // Garbage on the inputs while stalled must be ignored.
    mRead = 1'b1; mWrite = 1'b1; mByte = 1'b1; addr = 16'h0001; wData = 16'hDEAD;
    @(posedge clk);
    @(negedge clk);
    mRead = 1'b0; mWrite = 1'b0;
  endtask

  initial begin
    reset = 1'b1; addr = '0; wData = '0; mRead = 1'b0; mWrite = 1'b0; mByte = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready",  {31'd0, ready},  32'd1);
    check("rst_rvalid", {31'd0, rValid}, 32'd0);
    check("rst_err",    {31'd0, err},    32'd0);
    check("rst_data",   {16'd0, data},   32'd0);
    check("rst_memout", {31'd0, |memout}, 32'd0);
    reset = 1'b0;

    // 1: aligned word write/read of addr 0
    req(1'b0, 1'b1, 1'b0, 16'd0, 16'hBBBB);
    check("t1_wr_rvalid", {31'd0, rValid}, 32'd1);
    check("t1_wr_ready",  {31'd0, ready},  32'd1);
    check("t1_mem0",      {24'd0, mbyte(memout, 0)}, 32'h0000_00BB);
    check("t1_mem1",      {24'd0, mbyte(memout, 1)}, 32'h0000_00BB);
    req(1'b1, 1'b0, 1'b0, 16'd0, 16'h0000);
    check("t1_rd_rvalid", {31'd0, rValid}, 32'd1);
    check("t1_rd_ready",  {31'd0, ready},  32'd1);
    check("t1_rd_data",   {16'd0, data},   32'h0000_BBBB);

    // 2: misaligned word write/read at addr 3
    req_split(1'b0, 1'b1, 16'd3, 16'h1234, 16'hBBBB);
    check("t2_wr_rvalid", {31'd0, rValid}, 32'd1);
    check("t2_wr_ready",  {31'd0, ready},  32'd1);
    check("t2_wr_err",    {31'd0, err},    32'd0);
    check("t2_be_mem3",   {24'd0, mbyte(memout, 3)}, 32'h0000_0012);
    check("t2_be_mem4",   {24'd0, mbyte(memout, 4)}, 32'h0000_0034);
    check("t2_le_mem3",   {24'd0, mbyte(memout_le, 3)}, 32'h0000_0034);
    check("t2_le_mem4",   {24'd0, mbyte(memout_le, 4)}, 32'h0000_0012);
    check("t2_mem2",      {24'd0, mbyte(memout, 2)}, 32'h0000_0000);
    req_split(1'b1, 1'b0, 16'd3, 16'h0000, 16'hBBBB);
    check("t2_rd_rvalid", {31'd0, rValid}, 32'd1);
    check("t2_rd_data",   {16'd0, data},   32'h0000_1234);
    check("t2_le_rd_data",{16'd0, data_le}, 32'h0000_1234);
    @(negedge clk);
    check("t2_rvalid_pulse", {31'd0, rValid}, 32'd0);

    // 3: byte write/read at addr 7, zero- vs sign-extension
    req(1'b0, 1'b1, 1'b1, 16'd7, 16'hAA85);
    check("t3_mem7", {24'd0, mbyte(memout, 7)}, 32'h0000_0085);
    check("t3_mem6", {24'd0, mbyte(memout, 6)}, 32'h0000_0000);
    req(1'b1, 1'b0, 1'b1, 16'd7, 16'h0000);
    check("t3_zext", {16'd0, data},    32'h0000_0085);
    check("t3_sext", {16'd0, data_sx}, 32'h0000_FF85);

    // 4: range and illegal-op errors
    snap = memout;
    req_split(1'b0, 1'b1, 16'd55, 16'h1111, 16'h0085);
    check("t4_w55_rvalid", {31'd0, rValid}, 32'd1);
    check("t4_w55_err",    {31'd0, err},    32'd1);
    check("t4_w55_mem",    {31'd0, memout != snap}, 32'd0);
    check("t4_w55_data",   {16'd0, data},   32'h0000_0085);
    req(1'b0, 1'b1, 1'b1, 16'd56, 16'h0077);
    check("t4_b56_rvalid", {31'd0, rValid}, 32'd1);
    check("t4_b56_err",    {31'd0, err},    32'd1);
    check("t4_b56_mem",    {31'd0, memout != snap}, 32'd0);
    req(1'b1, 1'b1, 1'b0, 16'd10, 16'h4321);
    check("t4_rw_rvalid",  {31'd0, rValid}, 32'd1);
    check("t4_rw_err",     {31'd0, err},    32'd1);
    check("t4_rw_mem",     {31'd0, memout != snap}, 32'd0);
    check("t4_rw_data",    {16'd0, data},   32'h0000_0085);
    @(negedge clk);
    check("t4_err_pulse",  {31'd0, err},    32'd0);
    req(1'b0, 1'b1, 1'b0, 16'd54, 16'hCAFE);
    check("t4_w54_err",    {31'd0, err},    32'd0);
    check("t4_mem54",      {24'd0, mbyte(memout, 54)}, 32'h0000_00CA);
    check("t4_mem55",      {24'd0, mbyte(memout, 55)}, 32'h0000_00FE);
    req(1'b1, 1'b0, 1'b1, 16'd55, 16'h0000);
    check("t4_r55_err",    {31'd0, err},    32'd0);
    check("t4_r55_data",   {16'd0, data},   32'h0000_00FE);

    // 5: reset during the split stall of a write to addr 9
    mRead = 1'b0; mWrite = 1'b1; mByte = 1'b0; addr = 16'd9; wData = 16'h5AC3;
    @(posedge clk);
    @(negedge clk);
    check("t5_ready_low",  {31'd0, ready}, 32'd0);
    check("t5_mem9_first", {24'd0, mbyte(memout, 9)}, 32'h0000_005A);
    reset = 1'b1; mWrite = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("t5_memout_clr", {31'd0, |memout}, 32'd0);
    check("t5_rvalid",     {31'd0, rValid},  32'd0);
    check("t5_ready",      {31'd0, ready},   32'd1);
    check("t5_data",       {16'd0, data},    32'd0);
    @(posedge clk);
    @(negedge clk);
    check("t5_no_late_rvalid", {31'd0, rValid}, 32'd0);
    check("t5_mem10_clear",    {24'd0, mbyte(memout, 10)}, 32'd0);

    // 6: alternating write/read, every request accepted on consecutive edges
    for (int i = 0; i < 10; i++) begin
      logic [15:0] wd;
      wd = {8'(8'h11 * i + 8'h01), 8'(8'hF0 - i)};
      req(1'b0, 1'b1, 1'b0, 16'(2 * i), wd);
      check("t6_wr_rvalid", {31'd0, rValid}, 32'd1);
      check("t6_wr_ready",  {31'd0, ready},  32'd1);
      req(1'b1, 1'b0, 1'b0, 16'(2 * i), 16'h0000);
      check("t6_rd_rvalid", {31'd0, rValid}, 32'd1);
      check("t6_rd_data",   {16'd0, data},   {16'd0, wd});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
    $finish;
  end

endmodule
